// File: rtl/data_mem_responder.sv
// Load/store responder for the core's data port: one request at a time, WAIT_CYCLES wait states then a 1-cycle response.
// Latency: WAIT_CYCLES+1 cycles, or 1 cycle on error. Backpressure: req_ready is low while a request is in flight.
module data_mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_f3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int          MEM_AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [31:0] DEPTH_U   = DEPTH_WORDS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [2:0]        f3;
    logic [MEM_AW-1:0] idx;
    logic [1:0]        lane;
    logic [31:0]       wdata;
  } acc_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  acc_t        in_acc, cap, cur;
  logic        f3_bad, misaligned, out_of_range, req_err, cur_err;
  logic        xfer, commit;
  logic [31:0] req_idx_wide;
  logic [31:0] rword, load_val, wdat;
  logic [3:0]  be;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] mem [DEPTH_WORDS];

  // Request decode: errors are judged on the live inputs at the transfer edge.
  always_comb begin
    f3_bad     = 1'b0;
    misaligned = 1'b0;
    case (req_f3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = req_addr[0];
      3'b010:         misaligned = |req_addr[1:0];
      default:        f3_bad     = 1'b1;
    endcase
    if (req_we && req_f3[2]) f3_bad = 1'b1;
  end

  assign req_idx_wide = {{(32 - (ADDR_W - 2)){1'b0}}, req_addr[ADDR_W-1:2]};
  assign out_of_range = (req_idx_wide >= DEPTH_U);
  assign req_err      = f3_bad | misaligned | out_of_range;

  assign in_acc = '{we: req_we, f3: req_f3, idx: req_addr[MEM_AW+1:2],
                    lane: req_addr[1:0], wdata: req_wdata};

  assign xfer = req_valid & req_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = (req_err || NO_WAIT) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
      cap <= '0;
    end else if (state == IDLE && xfer) begin
      cap <= in_acc;
      cnt <= WAIT_INIT;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // A zero-wait or error transfer commits on the accept edge, so it must use the live request.
  assign cur     = (state == IDLE) ? in_acc : cap;
  assign cur_err = (state == IDLE) & req_err;
  assign commit  = (state != RESP) && (state_nxt == RESP);

  always_comb begin
    be   = 4'b1111;
    wdat = cur.wdata;
    case (cur.f3[1:0])
      2'b00: begin
        be   = 4'b0001 << cur.lane;
        wdat = {4{cur.wdata[7:0]}};
      end
      2'b01: begin
        be   = cur.lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{cur.wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign rword     = mem[cur.idx];
  assign lane_byte = rword[8*cur.lane +: 8];
  assign lane_half = cur.lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_val = 32'd0;
    case (cur.f3)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_val = {24'd0, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_val = {16'd0, lane_half};
      3'b010:  load_val = rword;
      default: load_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= cur_err;
      rsp_rdata <= (cur_err || cur.we) ? 32'd0 : load_val;
    end
  end

  // RAM contents survive reset; a store only lands when the FSM actually enters RESP.
  always_ff @(posedge clk) begin
    if (rst_n && commit && cur.we && !cur_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[cur.idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

endmodule
